// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, the writeback entry layout and the write-slot source encoding
// for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WB_W   = REG_AW + DATA_W;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_ALU,
        SRC_FIFO,
        SRC_HOLD
    } wb_src_e;

    function automatic logic [31:0] reg_onehot(input reg_addr_t a);
        logic [31:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Late-result buffer: synchronous FIFO with AW+1 bit pointers so full/empty
// are told apart by the pointer MSB. Storage is deliberately left unreset.
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = WB_W
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty     = (r_wptr == r_rptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: ALU results take the write port first, buffered late
// results fill idle slots; a pending scoreboard flags RAW hazards to decode.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        pause,
    input  logic        alu_wren,
    input  logic [4:0]  alu_wraddr,
    input  logic [31:0] alu_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wraddr,
    input  logic        lat_valid,
    input  logic [4:0]  lat_wraddr,
    input  logic [31:0] lat_data,
    output logic        lat_ready,
    input  logic [4:0]  rdaddr_a,
    input  logic [4:0]  rdaddr_b,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic        wren,
    output logic [4:0]  wraddress,
    output logic [31:0] data,
    output logic        err
);

    wb_entry_t   w_head;
    wb_entry_t   w_push_entry;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_alu_go;
    logic        w_iss_go;
    logic        w_err_evt;
    wb_src_e     w_src;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;
    logic [31:0] w_busy_nxt;

    logic [31:0] r_busy;
    logic        r_wren;
    reg_addr_t   r_wraddress;
    reg_data_t   r_data;
    logic        r_err;

    assign w_alu_go     = alu_wren && (alu_wraddr != '0);
    assign w_iss_go     = iss_valid && (iss_wraddr != '0);
    assign lat_ready    = !w_full;
    // R0 results are dropped at the door so they never occupy an entry.
    assign w_push       = lat_valid && !w_full && (lat_wraddr != '0);
    assign w_push_entry = '{addr: lat_wraddr, data: lat_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (WB_W)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_push_entry),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_src = SRC_IDLE;
        if (pause)          w_src = SRC_HOLD;
        else if (w_alu_go)  w_src = SRC_ALU;
        else if (!w_empty)  w_src = SRC_FIFO;
    end

    assign w_pop = (w_src == SRC_FIFO);

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (w_iss_go) w_busy_set = reg_onehot(iss_wraddr);
        if (w_pop)    w_busy_clr = reg_onehot(w_head.addr);
        w_busy_nxt = ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
    end

    assign w_err_evt = (w_iss_go && r_busy[iss_wraddr])
                    || ((w_src == SRC_ALU) && r_busy[alu_wraddr])
                    || (w_push && !r_busy[lat_wraddr]);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wren      <= 1'b0;
            r_wraddress <= '0;
            r_data      <= '0;
            r_busy      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_err_evt) r_err <= 1'b1;
            case (w_src)
                SRC_ALU: begin
                    r_wren      <= 1'b1;
                    r_wraddress <= alu_wraddr;
                    r_data      <= alu_data;
                end
                SRC_FIFO: begin
                    r_wren      <= 1'b1;
                    r_wraddress <= w_head.addr;
                    r_data      <= w_head.data;
                end
                SRC_IDLE: r_wren <= 1'b0;
                SRC_HOLD: ;
            endcase
        end
    end

    assign wren      = r_wren;
    assign wraddress = r_wraddress;
    assign data      = r_data;
    assign err       = r_err;
    assign hazard_a  = r_busy[rdaddr_a];
    assign hazard_b  = r_busy[rdaddr_b];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model of the writeback rules.
module tb_rf_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause, alu_wren, iss_valid, lat_valid;
    logic [4:0]  alu_wraddr, iss_wraddr, lat_wraddr, rdaddr_a, rdaddr_b;
    logic [31:0] alu_data, lat_data;
    logic        lat_ready, hazard_a, hazard_b, wren, err;
    logic [4:0]  wraddress;
    logic [31:0] data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [36:0] m_q[$];
    logic [31:0] m_busy;
    logic        m_wren, m_err;
    logic [4:0]  m_wraddr;
    logic [31:0] m_data;

    rf_wb_arbiter #(.DEPTH(DEPTH), .AW(2)) dut (
        .clock(clock), .rst_n(rst_n), .pause(pause),
        .alu_wren(alu_wren), .alu_wraddr(alu_wraddr), .alu_data(alu_data),
        .iss_valid(iss_valid), .iss_wraddr(iss_wraddr),
        .lat_valid(lat_valid), .lat_wraddr(lat_wraddr), .lat_data(lat_data),
        .lat_ready(lat_ready), .rdaddr_a(rdaddr_a), .rdaddr_b(rdaddr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .wren(wren), .wraddress(wraddress), .data(data), .err(err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic idle();
        pause = 0; alu_wren = 0; alu_wraddr = 0; alu_data = 0;
        iss_valid = 0; iss_wraddr = 0; lat_valid = 0; lat_wraddr = 0; lat_data = 0;
        rdaddr_a = 0; rdaddr_b = 0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_wren = 0; m_wraddr = 0; m_data = 0; m_err = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        #2;
        @(posedge clock); #1;
        rst_n = 1;
    endtask

    // Apply the writeback rules to the current inputs, then advance one edge.
    task automatic step();
        bit alu_go, push, pop;
        logic [36:0] head;
        logic [31:0] nb;
        alu_go = alu_wren && alu_wraddr != 0;
        push   = lat_valid && (m_q.size() < DEPTH) && lat_wraddr != 0;
        pop    = !pause && !alu_go && m_q.size() > 0;
        if (iss_valid && iss_wraddr != 0 && m_busy[iss_wraddr]) m_err = 1;
        if (!pause && alu_go && m_busy[alu_wraddr]) m_err = 1;
        if (push && !m_busy[lat_wraddr]) m_err = 1;
        nb = m_busy;
        if (!pause) begin
            if (alu_go) begin
                m_wren = 1; m_wraddr = alu_wraddr; m_data = alu_data;
            end else if (pop) begin
                head = m_q.pop_front();
                m_wren = 1; m_wraddr = head[36:32]; m_data = head[31:0];
                nb[head[36:32]] = 0;
            end else begin
                m_wren = 0;
            end
        end
        if (push) m_q.push_back({lat_wraddr, lat_data});
        if (iss_valid && iss_wraddr != 0) nb[iss_wraddr] = 1;
        m_busy = nb;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        n_tests++;
        if ({wren, wraddress, data, err, lat_ready, hazard_a, hazard_b} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got wren=%b addr=%0d data=%h err=%b rdy=%b hz=%b%b want 0/0/0/0/1/00",
                     wren, wraddress, data, err, lat_ready, hazard_a, hazard_b);
        end
        alu_wren = 1; alu_wraddr = 3; alu_data = 32'hA5A5_0003;
        step();
        idle();
        rst_n = 0; model_reset();
        #1;
        n_tests++;
        if ({wren, wraddress, data} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL async_reset got wren=%b addr=%0d data=%h want 0/0/0", wren, wraddress, data);
        end
        @(posedge clock); #1;
        rst_n = 1;
    endtask

    task automatic test_alu();
        alu_wren = 1; alu_wraddr = 5; alu_data = 32'h1234_5678;
        step();
        n_tests++;
        if ({wren, wraddress, data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL alu_write got %b/%0d/%h want 1/5/12345678", wren, wraddress, data);
        end
        idle();
        step();
        n_tests++;
        if ({wren, wraddress, data} !== {1'b0, 5'd5, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL alu_idle_hold got %b/%0d/%h want 0/5/12345678", wren, wraddress, data);
        end
    endtask

    task automatic test_late();
        iss_valid = 1; iss_wraddr = 9;
        step();
        idle(); rdaddr_a = 9; #1;
        n_tests++;
        if ({hazard_a, hazard_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL late_hazard_set got %b%b want 10", hazard_a, hazard_b);
        end
        lat_valid = 1; lat_wraddr = 9; lat_data = 32'hCAFE_F00D;
        step();
        lat_valid = 0;
        n_tests++;
        if (wren !== 1'b0) begin
            n_fail++;
            $display("FAIL late_no_bypass got wren=%b want 0", wren);
        end
        step();
        n_tests++;
        if ({wren, wraddress, data, hazard_a} !== {1'b1, 5'd9, 32'hCAFE_F00D, 1'b0}) begin
            n_fail++;
            $display("FAIL late_write got %b/%0d/%h hz=%b want 1/9/cafef00d hz=0", wren, wraddress, data, hazard_a);
        end
    endtask

    task automatic test_fill_drain();
        for (int r = 2; r <= 5; r++) begin
            idle(); iss_valid = 1; iss_wraddr = 5'(r);
            step();
        end
        for (int r = 2; r <= 5; r++) begin
            idle();
            alu_wren = 1; alu_wraddr = 1; alu_data = 32'h1000 + r;
            lat_valid = 1; lat_wraddr = 5'(r); lat_data = 32'hD000_0000 + r;
            step();
            n_tests++;
            if ({wren, wraddress, lat_ready} !== {1'b1, 5'd1, (r != 5)}) begin
                n_fail++;
                $display("FAIL fill_%0d got wren=%b addr=%0d rdy=%b want 1/1/%b", r, wren, wraddress, lat_ready, (r != 5));
            end
        end
        idle();
        for (int r = 2; r <= 5; r++) begin
            step();
            n_tests++;
            if ({wren, wraddress, data} !== {1'b1, 5'(r), 32'hD000_0000 + r}) begin
                n_fail++;
                $display("FAIL drain_%0d got %b/%0d/%h want 1/%0d/%h", r, wren, wraddress, data, r, 32'hD000_0000 + r);
            end
        end
        step();
        rdaddr_a = 2; rdaddr_b = 5; #1;
        n_tests++;
        if ({wren, lat_ready, hazard_a, hazard_b} !== 4'b0100) begin
            n_fail++;
            $display("FAIL drain_done got wren=%b rdy=%b hz=%b%b want 0/1/00", wren, lat_ready, hazard_a, hazard_b);
        end
    endtask

    task automatic test_pause();
        idle(); iss_valid = 1; iss_wraddr = 10;
        step();
        idle(); iss_valid = 1; iss_wraddr = 11;
        alu_wren = 1; alu_wraddr = 20; alu_data = 32'h0000_0020;
        step();
        for (int c = 0; c < 3; c++) begin
            idle(); pause = 1;
            alu_wren = 1; alu_wraddr = 21; alu_data = 32'hBAD0_0021;
            if (c < 2) begin
                lat_valid = 1; lat_wraddr = 5'(10 + c); lat_data = 32'hE000_0000 + c;
            end
            step();
            n_tests++;
            if ({wren, wraddress, data} !== {1'b1, 5'd20, 32'h0000_0020}) begin
                n_fail++;
                $display("FAIL pause_freeze_%0d got %b/%0d/%h want 1/20/00000020", c, wren, wraddress, data);
            end
        end
        idle();
        for (int c = 0; c < 2; c++) begin
            step();
            n_tests++;
            if ({wren, wraddress, data} !== {1'b1, 5'(10 + c), 32'hE000_0000 + c}) begin
                n_fail++;
                $display("FAIL pause_drain_%0d got %b/%0d/%h want 1/%0d/%h", c, wren, wraddress, data, 10 + c, 32'hE000_0000 + c);
            end
        end
    endtask

    task automatic test_r0();
        idle(); alu_wren = 1; alu_wraddr = 0; alu_data = 32'hFFFF_FFFF;
        step();
        n_tests++;
        if (wren !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_alu got wren=%b want 0", wren);
        end
        idle(); lat_valid = 1; lat_wraddr = 0; lat_data = 32'h0BAD_0BAD;
        step();
        idle();
        step();
        n_tests++;
        if ({wren, lat_ready, err} !== 3'b010) begin
            n_fail++;
            $display("FAIL r0_late got wren=%b rdy=%b err=%b want 0/1/0", wren, lat_ready, err);
        end
    endtask

    task automatic test_err();
        idle(); iss_valid = 1; iss_wraddr = 7;
        step();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_first_issue got %b want 0", err);
        end
        step();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_double_issue got %b want 1", err);
        end
        idle();
        step(); step(); step();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky got %b want 1", err);
        end
        do_reset();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reset got %b want 0", err);
        end
        iss_valid = 1; iss_wraddr = 8;
        step();
        idle(); alu_wren = 1; alu_wraddr = 8; alu_data = 32'h88;
        step();
        n_tests++;
        if ({err, wren, wraddress} !== {1'b1, 1'b1, 5'd8}) begin
            n_fail++;
            $display("FAIL err_waw got err=%b wren=%b addr=%0d want 1/1/8", err, wren, wraddress);
        end
        do_reset();
        lat_valid = 1; lat_wraddr = 12; lat_data = 32'h1212_1212;
        step();
        idle();
        step();
        n_tests++;
        if ({err, wren, wraddress, data} !== {1'b1, 1'b1, 5'd12, 32'h1212_1212}) begin
            n_fail++;
            $display("FAIL err_unissued got err=%b %b/%0d/%h want 1 1/12/12121212", err, wren, wraddress, data);
        end
        do_reset();
    endtask

    // Legal traffic: issue only free registers, return results only for outstanding ones.
    task automatic test_random_legal();
        logic [4:0] pend[$];
        for (int c = 0; c < 300; c++) begin
            logic [4:0] r, a;
            bit do_iss, exp_rdy;
            idle();
            pause = ($urandom_range(0, 7) == 0);
            r = 5'($urandom_range(1, 15));
            do_iss = ($urandom_range(0, 2) == 0) && !m_busy[r];
            if (do_iss) begin iss_valid = 1; iss_wraddr = r; end
            a = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1 && !m_busy[a]) begin
                alu_wren = 1; alu_wraddr = a; alu_data = $urandom;
            end
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                lat_valid = 1; lat_wraddr = pend[0]; lat_data = $urandom;
                if (m_q.size() < DEPTH) void'(pend.pop_front());
            end
            step();
            if (do_iss) pend.push_back(r);
            exp_rdy = (m_q.size() < DEPTH);
            n_tests++;
            if ({wren, wraddress, data, err, lat_ready} !== {m_wren, m_wraddr, m_data, m_err, exp_rdy}) begin
                n_fail++;
                $display("FAIL legal_out c=%0d got %b/%0d/%h err=%b rdy=%b want %b/%0d/%h err=%b rdy=%b",
                         c, wren, wraddress, data, err, lat_ready, m_wren, m_wraddr, m_data, m_err, exp_rdy);
            end
            rdaddr_a = 5'($urandom_range(0, 15)); rdaddr_b = 5'($urandom_range(0, 15)); #1;
            n_tests++;
            if ({hazard_a, hazard_b} !== {m_busy[rdaddr_a], m_busy[rdaddr_b]}) begin
                n_fail++;
                $display("FAIL legal_hazard c=%0d got %b%b want %b%b", c, hazard_a, hazard_b, m_busy[rdaddr_a], m_busy[rdaddr_b]);
            end
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL legal_no_err got %b want 0", err);
        end
    endtask

    task automatic test_random_chaos();
        do_reset();
        for (int c = 0; c < 200; c++) begin
            bit exp_rdy;
            pause      = ($urandom_range(0, 5) == 0);
            alu_wren   = $urandom_range(0, 1);
            alu_wraddr = 5'($urandom_range(0, 7));
            alu_data   = $urandom;
            iss_valid  = ($urandom_range(0, 3) == 0);
            iss_wraddr = 5'($urandom_range(0, 7));
            lat_valid  = $urandom_range(0, 1);
            lat_wraddr = 5'($urandom_range(0, 7));
            lat_data   = $urandom;
            step();
            exp_rdy = (m_q.size() < DEPTH);
            n_tests++;
            if ({wren, wraddress, data, err, lat_ready} !== {m_wren, m_wraddr, m_data, m_err, exp_rdy}) begin
                n_fail++;
                $display("FAIL chaos_out c=%0d got %b/%0d/%h err=%b rdy=%b want %b/%0d/%h err=%b rdy=%b",
                         c, wren, wraddress, data, err, lat_ready, m_wren, m_wraddr, m_data, m_err, exp_rdy);
            end
            rdaddr_a = 5'($urandom_range(0, 7)); rdaddr_b = 5'($urandom_range(0, 7)); #1;
            n_tests++;
            if ({hazard_a, hazard_b} !== {m_busy[rdaddr_a], m_busy[rdaddr_b]}) begin
                n_fail++;
                $display("FAIL chaos_hazard c=%0d got %b%b want %b%b", c, hazard_a, hazard_b, m_busy[rdaddr_a], m_busy[rdaddr_b]);
            end
        end
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_alu();
        test_late();
        test_fill_drain();
        test_pause();
        test_r0();
        test_err();
        test_random_legal();
        test_random_chaos();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
